// File: rtl/college_board_regs.sv
// Role-restricted score register block: teacher writes all fields, principal overrides lab,
// student reads a registered snapshot. Define COLLEGE_BOARD_AUDIT_EN to add a principal write counter.
module college_board_regs #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RST_MATH    = '0,
    parameter logic [WIDTH-1:0] RST_PHYSICS = '0,
    parameter logic [WIDTH-1:0] RST_LAB     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             teacher_we,
    input  logic [WIDTH-1:0] teacher_math,
    input  logic [WIDTH-1:0] teacher_physics,
    input  logic [WIDTH-1:0] teacher_lab,
    input  logic             principal_lab_we,
    input  logic [WIDTH-1:0] principal_lab,
    output logic [WIDTH-1:0] principal_math_rd,
    output logic [WIDTH-1:0] principal_physics_rd,
    output logic [WIDTH-1:0] principal_lab_rd,
    output logic             lab_overridden,
`ifdef COLLEGE_BOARD_AUDIT_EN
    output logic [7:0]       principal_write_count,
`endif
    input  logic             student_req,
    output logic [WIDTH-1:0] student_math,
    output logic [WIDTH-1:0] student_physics,
    output logic [WIDTH-1:0] student_lab,
    output logic             student_valid
);

    logic [WIDTH-1:0] math_q, math_d;
    logic [WIDTH-1:0] physics_q, physics_d;
    logic [WIDTH-1:0] lab_q, lab_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] snap_math_q, snap_math_d;
    logic [WIDTH-1:0] snap_physics_q, snap_physics_d;
    logic [WIDTH-1:0] snap_lab_q, snap_lab_d;
    logic             valid_q, valid_d;

    // Principal strobe is applied last so it wins on lab when both roles write.
    always_comb begin
        math_d    = math_q;
        physics_d = physics_q;
        lab_d     = lab_q;
        ovr_d     = ovr_q;
        if (teacher_we) begin
            math_d    = teacher_math;
            physics_d = teacher_physics;
            lab_d     = teacher_lab;
            ovr_d     = 1'b0;
        end
        if (principal_lab_we) begin
            lab_d = principal_lab;
            ovr_d = 1'b1;
        end
    end

    // Snapshot samples the current registers, i.e. the values before this edge's writes.
    always_comb begin
        snap_math_d    = snap_math_q;
        snap_physics_d = snap_physics_q;
        snap_lab_d     = snap_lab_q;
        valid_d        = student_req;
        if (student_req) begin
            snap_math_d    = math_q;
            snap_physics_d = physics_q;
            snap_lab_d     = lab_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            math_q         <= RST_MATH;
            physics_q      <= RST_PHYSICS;
            lab_q          <= RST_LAB;
            ovr_q          <= 1'b0;
            snap_math_q    <= '0;
            snap_physics_q <= '0;
            snap_lab_q     <= '0;
            valid_q        <= 1'b0;
        end else begin
            math_q         <= math_d;
            physics_q      <= physics_d;
            lab_q          <= lab_d;
            ovr_q          <= ovr_d;
            snap_math_q    <= snap_math_d;
            snap_physics_q <= snap_physics_d;
            snap_lab_q     <= snap_lab_d;
            valid_q        <= valid_d;
        end
    end

`ifdef COLLEGE_BOARD_AUDIT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (principal_lab_we && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign principal_write_count = cnt_q;
`endif

    assign principal_math_rd    = math_q;
    assign principal_physics_rd = physics_q;
    assign principal_lab_rd     = lab_q;
    assign lab_overridden       = ovr_q;
    assign student_math         = snap_math_q;
    assign student_physics      = snap_physics_q;
    assign student_lab          = snap_lab_q;
    assign student_valid        = valid_q;

endmodule

// File: tb/tb_college_board_regs.sv
// Directed self-checking bench for college_board_regs; audit counter checks compile in
// when COLLEGE_BOARD_AUDIT_EN is defined.
module tb_college_board_regs;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             teacher_we;
    logic [WIDTH-1:0] teacher_math, teacher_physics, teacher_lab;
    logic             principal_lab_we;
    logic [WIDTH-1:0] principal_lab;
    logic [WIDTH-1:0] principal_math_rd, principal_physics_rd, principal_lab_rd;
    logic             lab_overridden;
    logic             student_req;
    logic [WIDTH-1:0] student_math, student_physics, student_lab;
    logic             student_valid;
`ifdef COLLEGE_BOARD_AUDIT_EN
    logic [7:0]       principal_write_count;
`endif

    int errors = 0;
    int checks = 0;

    college_board_regs #(.WIDTH(WIDTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .teacher_we           (teacher_we),
        .teacher_math         (teacher_math),
        .teacher_physics      (teacher_physics),
        .teacher_lab          (teacher_lab),
        .principal_lab_we     (principal_lab_we),
        .principal_lab        (principal_lab),
        .principal_math_rd    (principal_math_rd),
        .principal_physics_rd (principal_physics_rd),
        .principal_lab_rd     (principal_lab_rd),
        .lab_overridden       (lab_overridden),
`ifdef COLLEGE_BOARD_AUDIT_EN
        .principal_write_count(principal_write_count),
`endif
        .student_req          (student_req),
        .student_math         (student_math),
        .student_physics      (student_physics),
        .student_lab          (student_lab),
        .student_valid        (student_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input int m, input int p, input int l, input int ov);
        chk({tag, ".math"}, 32'(principal_math_rd), m[31:0]);
        chk({tag, ".physics"}, 32'(principal_physics_rd), p[31:0]);
        chk({tag, ".lab"}, 32'(principal_lab_rd), l[31:0]);
        chk({tag, ".ovr"}, 32'(lab_overridden), ov[31:0]);
    endtask

    task automatic chk_snap(input string tag, input int m, input int p, input int l, input int v);
        chk({tag, ".smath"}, 32'(student_math), m[31:0]);
        chk({tag, ".sphysics"}, 32'(student_physics), p[31:0]);
        chk({tag, ".slab"}, 32'(student_lab), l[31:0]);
        chk({tag, ".svalid"}, 32'(student_valid), v[31:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        teacher_we       = 1'b0;
        principal_lab_we = 1'b0;
        student_req      = 1'b0;
    endtask

    task automatic teach(input int m, input int p, input int l);
        teacher_we      = 1'b1;
        teacher_math    = m[WIDTH-1:0];
        teacher_physics = p[WIDTH-1:0];
        teacher_lab     = l[WIDTH-1:0];
    endtask

    initial begin
        rst = 1'b1;
        idle();
        teacher_math = '0; teacher_physics = '0; teacher_lab = '0; principal_lab = '0;
        tick();
        chk_regs("por", 0, 0, 0, 0);
        chk_snap("por", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Teacher write
        teach(85, 90, 95);
        tick();
        idle();
        chk_regs("teacher", 85, 90, 95, 0);

        // Principal override
        principal_lab_we = 1'b1;
        principal_lab    = 8'd99;
        tick();
        idle();
        chk_regs("override", 85, 90, 99, 1);

        student_req = 1'b1;
        tick();
        idle();
        chk_snap("snap1", 85, 90, 99, 1);
        tick();
        chk_snap("snap1_drop", 85, 90, 99, 0);
        chk_regs("hold", 85, 90, 99, 1);

        // Same-cycle request and teacher write returns pre-write values
        teach(1, 2, 3);
        student_req = 1'b1;
        tick();
        idle();
        chk_snap("rw_old", 85, 90, 99, 1);
        chk_regs("rw_regs", 1, 2, 3, 0);

        // Back-to-back requests, second one after another write
        student_req = 1'b1;
        teach(4, 5, 6);
        tick();
        teacher_we = 1'b0;
        chk_snap("b2b_a", 1, 2, 3, 1);
        tick();
        idle();
        chk_snap("b2b_b", 4, 5, 6, 1);

        // Simultaneous teacher and principal write
        teach(10, 20, 30);
        principal_lab_we = 1'b1;
        principal_lab    = 8'd77;
        tick();
        idle();
        chk_regs("simul", 10, 20, 77, 1);
        tick();
        chk_regs("simul_hold", 10, 20, 77, 1);
        chk_snap("simul_nosnap", 4, 5, 6, 0);

        // Mid-cycle asynchronous reset with a request and write in flight
        student_req = 1'b1;
        teach(200, 201, 202);
        #2;
        rst = 1'b1;
        #1;
        chk_regs("async_rst", 0, 0, 0, 0);
        chk_snap("async_rst", 0, 0, 0, 0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        teach(7, 8, 9);
        tick();
        idle();
        chk_regs("post_rst", 7, 8, 9, 0);
        chk_snap("post_rst", 0, 0, 0, 0);

`ifdef COLLEGE_BOARD_AUDIT_EN
        chk("audit_zero", 32'(principal_write_count), 32'd0);
        principal_lab_we = 1'b1;
        for (int i = 0; i < 260; i++) begin
            principal_lab = i[WIDTH-1:0];
            tick();
            if (i == 9) chk("audit_10", 32'(principal_write_count), 32'd10);
        end
        idle();
        tick();
        chk("audit_sat", 32'(principal_write_count), 32'd255);
        chk("audit_lab", 32'(principal_lab_rd), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
